// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared frame geometry, widths and corner/state encodings
package vid_pkg;

    localparam int VID_IN_WIDTH  = 320;
    localparam int VID_IN_HEIGHT = 240;
    localparam int ADDR_W        = 17;
    localparam int INT_W         = 25;
    localparam int COORD_W       = 9;

    typedef enum logic [1:0] {
        CORNER_D = 2'd0,
        CORNER_B = 2'd1,
        CORNER_C = 2'd2,
        CORNER_A = 2'd3
    } corner_e;

    typedef struct packed {
        logic    valid;
        corner_e id;
    } tag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SUM,
        S_DONE
    } state_e;

    // Linear integral-memory address of (y,x).
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] x);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        return yy * ADDR_W'(VID_IN_WIDTH) + ADDR_W'(x);
    endfunction

    // Rectangle must be ordered and lie entirely inside the frame.
    function automatic logic query_ok(input logic [COORD_W-1:0] x0,
                                      input logic [COORD_W-1:0] y0,
                                      input logic [COORD_W-1:0] x1,
                                      input logic [COORD_W-1:0] y1);
        return (x0 <= x1) && (y0 <= y1) &&
               (x1 < COORD_W'(VID_IN_WIDTH)) && (y1 < COORD_W'(VID_IN_HEIGHT));
    endfunction

endpackage

// File: rtl/box_sum_addr_gen.sv
// rtl/box_sum_addr_gen.sv - walks the present corners of a latched query, D,B,C,A order
module box_sum_addr_gen
    import vid_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    input  logic               issue_i,
    output logic [ADDR_W-1:0]  addr_o,
    output corner_e            tag_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [3:0]         pending_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         sel_bit;
    corner_e            sel_tag;
    logic [ADDR_W-1:0]  sel_addr;

    // Pick the next outstanding corner; bit index equals the corner encoding.
    always_comb begin
        sel_bit  = 4'b0000;
        sel_tag  = CORNER_D;
        sel_addr = pix_addr(y1_q, x1_q);
        if (pending_q[0]) begin
            sel_bit  = 4'b0001;
            sel_tag  = CORNER_D;
            sel_addr = pix_addr(y1_q, x1_q);
        end else if (pending_q[1]) begin
            sel_bit  = 4'b0010;
            sel_tag  = CORNER_B;
            sel_addr = pix_addr(y0_q - 1'b1, x1_q);
        end else if (pending_q[2]) begin
            sel_bit  = 4'b0100;
            sel_tag  = CORNER_C;
            sel_addr = pix_addr(y1_q, x0_q - 1'b1);
        end else if (pending_q[3]) begin
            sel_bit  = 4'b1000;
            sel_tag  = CORNER_A;
            sel_addr = pix_addr(y0_q - 1'b1, x0_q - 1'b1);
        end
    end

    assign tag_o  = sel_tag;
    assign last_o = (pending_q != 4'b0000) && ((pending_q & ~sel_bit) == 4'b0000);
    assign addr_o = addr_q;

    // Latch query and corner mask on load; retire one corner per issue strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            pending_q <= 4'b0000;
            addr_q    <= '0;
        end else if (load_i) begin
            x0_q      <= x0_i;
            y0_q      <= y0_i;
            x1_q      <= x1_i;
            y1_q      <= y1_i;
            pending_q <= {(x0_i != '0) && (y0_i != '0), (x0_i != '0), (y0_i != '0), 1'b1};
        end else if (issue_i && (pending_q != 4'b0000)) begin
            addr_q    <= sel_addr;
            pending_q <= pending_q & ~sel_bit;
        end
    end

endmodule

// File: rtl/box_sum_reader.sv
// rtl/box_sum_reader.sv - rectangle sum query engine over the integral-image M10K
module box_sum_reader
    import vid_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               int_ready,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x0,
    input  logic [COORD_W-1:0] req_x1,
    input  logic [COORD_W-1:0] req_y0,
    input  logic [COORD_W-1:0] req_y1,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_en,
    input  logic [INT_W-1:0]   rd_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [INT_W-1:0]   res_sum,
    output logic               res_err
);

    state_e             state_q;
    tag_t               pipe_q [READ_LATENCY];
    logic [INT_W-1:0]   hold_q [4];
    logic [2:0]         iss_cnt_q, ret_cnt_q;
    logic               rd_en_q, res_valid_q, res_err_q;
    logic [INT_W-1:0]   res_sum_q;
    logic               accept, q_ok, issue, gen_last;
    corner_e            gen_tag;

    assign req_ready = (state_q == S_IDLE) && int_ready && !reset;
    assign accept    = req_valid && req_ready;
    assign q_ok      = query_ok(req_x0, req_y0, req_x1, req_y1);
    assign issue     = (state_q == S_ISSUE);

    box_sum_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept && q_ok),
        .x0_i    (req_x0),
        .y0_i    (req_y0),
        .x1_i    (req_x1),
        .y1_i    (req_y1),
        .issue_i (issue),
        .addr_o  (rd_addr),
        .tag_o   (gen_tag),
        .last_o  (gen_last)
    );

    assign rd_en     = rd_en_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_err   = res_err_q;

    // Query FSM with tag pipe, corner capture and final D - B - C + A.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_sum_q   <= '0;
            iss_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
        end else begin
            rd_en_q   <= issue;
            pipe_q[0] <= '{valid: issue, id: gen_tag};
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            if (pipe_q[READ_LATENCY-1].valid) begin
                hold_q[pipe_q[READ_LATENCY-1].id] <= rd_data;
                ret_cnt_q <= ret_cnt_q + 3'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        iss_cnt_q <= '0;
                        ret_cnt_q <= '0;
                        for (int i = 0; i < 4; i++) hold_q[i] <= '0;
                        state_q <= q_ok ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    iss_cnt_q <= iss_cnt_q + 3'd1;
                    if (gen_last) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (ret_cnt_q == iss_cnt_q) state_q <= S_SUM;
                end
                S_SUM: begin
                    res_sum_q   <= hold_q[CORNER_D] - hold_q[CORNER_B]
                                 - hold_q[CORNER_C] + hold_q[CORNER_A];
                    res_err_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    // Entering DONE with res_valid low only happens for a rejected query.
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        res_sum_q   <= '0;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_box_sum_reader.sv
// tb/tb_box_sum_reader.sv - directed self-checking bench for box_sum_reader
module tb_box_sum_reader;

    logic        clk = 1'b0;
    logic        reset, int_ready, req_valid, req_ready;
    logic [8:0]  req_x0, req_x1, req_y0, req_y1;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [24:0] rd_data;
    logic        res_valid, res_ready, res_err;
    logic [24:0] res_sum;

    int errors = 0;
    int checks = 0;
    int got_addrs[$];
    int got_lat;

    box_sum_reader dut (
        .clk       (clk),
        .reset     (reset),
        .int_ready (int_ready),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .req_y0    (req_y0),
        .req_y1    (req_y1),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_err   (res_err)
    );

    always #10 clk = ~clk;

    // Integral M10K of an all-ones image: q register loads I(addr) one edge after rd_addr.
    always @(posedge clk) begin
        int a;
        a = int'(rd_addr);
        rd_data <= 25'((a / 320 + 1) * (a % 320 + 1));
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a query, then record reads and the edge (after acceptance) where res_valid rises.
    task automatic run_query(input int x0, input int y0, input int x1, input int y1);
        int waited;
        got_addrs.delete();
        got_lat = -1;
        req_x0 = 9'(x0); req_y0 = 9'(y0); req_x1 = 9'(x1); req_y1 = 9'(y1);
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        req_valid = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (rd_en) got_addrs.push_back(int'(rd_addr));
            if (res_valid) begin
                got_lat = e;
                break;
            end
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    typedef struct {
        string name;
        int x0, y0, x1, y1;
        int n;
        int a0, a1, a2, a3;
        int sum, err, lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad_rd, bad_rv;
        vecs[0] = '{"pix00",   0,  0,   0,   0, 1,     0,    -1,   -1,   -1,     1, 0, 5};
        vecs[1] = '{"box10",  10, 20,  19,  29, 4,  9299,  6099, 9289, 6089,   100, 0, 8};
        vecs[2] = '{"frame",   0,  0, 319, 239, 1, 76799,    -1,   -1,   -1, 76800, 0, 5};
        vecs[3] = '{"frx1",    1,  0, 319, 239, 2, 76799, 76480,   -1,   -1, 76560, 0, 6};
        vecs[4] = '{"x1_320",  0,  0, 320,   0, 0,    -1,    -1,   -1,   -1,     0, 1, 1};
        vecs[5] = '{"x0gtx1",  5,  0,   4,   0, 0,    -1,    -1,   -1,   -1,     0, 1, 1};
        vecs[6] = '{"pix32",   3,  2,   3,   2, 4,   643,   323,  642,  322,     1, 0, 8};
        vecs[7] = '{"y1_240",  0,  0,   0, 240, 0,    -1,    -1,   -1,   -1,     0, 1, 1};

        reset = 1'b1; int_ready = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
        repeat (3) tick();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rd_addr", rd_addr, 0);
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_sum", res_sum, 0);
        check_val("rst_res_err", res_err, 0);
        reset = 1'b0;

        // int_ready low: request must be ignored.
        req_x0 = 9'd0; req_y0 = 9'd0; req_x1 = 9'd5; req_y1 = 9'd5;
        req_valid = 1'b1;
        bad_rd = 0; bad_rv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("noint_req_ready", req_ready, 0);
            if (rd_en) bad_rd++;
            if (res_valid) bad_rv++;
        end
        check_val("noint_rd_en", bad_rd, 0);
        check_val("noint_res_valid", bad_rv, 0);
        req_valid = 1'b0;
        int_ready = 1'b1;
        tick();

        foreach (vecs[v]) begin
            int exp_a[4];
            exp_a[0] = vecs[v].a0; exp_a[1] = vecs[v].a1;
            exp_a[2] = vecs[v].a2; exp_a[3] = vecs[v].a3;
            run_query(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1);
            check_val({vecs[v].name, "_nreads"}, got_addrs.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n && k < got_addrs.size(); k++)
                check_val($sformatf("%s_addr%0d", vecs[v].name, k), got_addrs[k], exp_a[k]);
            check_val({vecs[v].name, "_lat"}, got_lat, vecs[v].lat);
            check_val({vecs[v].name, "_sum"}, res_sum, vecs[v].sum);
            check_val({vecs[v].name, "_err"}, res_err, vecs[v].err);
            take_result();
            check_val({vecs[v].name, "_released"}, res_valid, 0);
        end

        // Backpressure: result must hold, no new acceptance or reads.
        run_query(10, 20, 19, 29);
        check_val("bp_lat", got_lat, 8);
        req_x0 = 9'd0; req_y0 = 9'd0; req_x1 = 9'd0; req_y1 = 9'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("bp_res_valid", res_valid, 1);
            check_val("bp_res_sum", res_sum, 100);
            check_val("bp_req_ready", req_ready, 0);
            check_val("bp_rd_en", rd_en, 0);
        end
        req_valid = 1'b0;
        take_result();

        // Reset two edges into a 4-corner query.
        req_x0 = 9'd10; req_y0 = 9'd20; req_x1 = 9'd19; req_y1 = 9'd29;
        req_valid = 1'b1;
        check_val("mid_pre_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("mid_req_ready", req_ready, 0);
        check_val("mid_rd_addr", rd_addr, 0);
        check_val("mid_rd_en", rd_en, 0);
        check_val("mid_res_valid", res_valid, 0);
        check_val("mid_res_sum", res_sum, 0);
        check_val("mid_res_err", res_err, 0);
        reset = 1'b0;
        bad_rd = 0; bad_rv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_en) bad_rd++;
            if (res_valid) bad_rv++;
        end
        check_val("post_rst_rd_en", bad_rd, 0);
        check_val("post_rst_res_valid", bad_rv, 0);

        run_query(3, 2, 3, 2);
        check_val("after_rst_nreads", got_addrs.size(), 4);
        check_val("after_rst_lat", got_lat, 8);
        check_val("after_rst_sum", res_sum, 1);
        check_val("after_rst_err", res_err, 0);
        take_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
